// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensors and credit enable in, coin code and status out.
// Optional audit counters are present only when COIN_ACCEPTOR_AUDIT_EN is defined.
interface coin_acceptor_if;
  logic       sense_5;
  logic       sense_10;
  logic       accept_en;
  logic [1:0] coin;
  logic       reject;
  logic       busy;
`ifdef COIN_ACCEPTOR_AUDIT_EN
  logic [7:0] accepted_cnt;
  logic [7:0] rejected_cnt;

  modport master (
    output sense_5, sense_10, accept_en,
    input  coin, reject, busy, accepted_cnt, rejected_cnt
  );

  modport slave (
    input  sense_5, sense_10, accept_en,
    output coin, reject, busy, accepted_cnt, rejected_cnt
  );
`else
  modport master (
    output sense_5, sense_10, accept_en,
    input  coin, reject, busy
  );

  modport slave (
    input  sense_5, sense_10, accept_en,
    output coin, reject, busy
  );
`endif
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces the 5/10-rupee slot sensors and
// emits one single-cycle coin code (or reject pulse) per physical insertion.
// Optional feature macro: COIN_ACCEPTOR_AUDIT_EN adds saturating 8-bit
// accepted/rejected counters on the interface.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no coin present, waiting for a nonzero sensor pattern
// DEBOUNCE | pattern latched, counting consecutive stable samples
// RELEASE  | decision made (or reset), waiting for the slot to be empty
// HOLDOFF  | slot empty, ignoring sensors for the gap period
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 8
) (
  input logic            clk,
  input logic            rst_n,
  coin_acceptor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_HOLDOFF  = 2'd3
  } state_t;

  // Terminal-count values; the shared counter is 8 bits so GAP up to 255 fits.
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic       r_s5_meta;
  logic       r_s5_sync;
  logic       r_s10_meta;
  logic       r_s10_sync;
  logic [1:0] w_pat;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [1:0] r_latch;
  logic [1:0] w_latch_nxt;
  logic [1:0] r_coin;
  logic [1:0] w_coin_nxt;
  logic       r_reject;
  logic       w_reject_nxt;

  // Two-flop synchronisers for the asynchronous optical sensors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s5_meta  <= 1'b0;
      r_s5_sync  <= 1'b0;
      r_s10_meta <= 1'b0;
      r_s10_sync <= 1'b0;
    end else begin
      r_s5_meta  <= bus.sense_5;
      r_s5_sync  <= r_s5_meta;
      r_s10_meta <= bus.sense_10;
      r_s10_sync <= r_s10_meta;
    end
  end

  assign w_pat = {r_s10_sync, r_s5_sync};

  // State, counter, latched pattern and registered decision outputs.
  // Reset lands in RELEASE so a coin already in the slot is never credited.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RELEASE;
      r_cnt    <= 8'd0;
      r_latch  <= 2'b00;
      r_coin   <= 2'b00;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_latch  <= w_latch_nxt;
      r_coin   <= w_coin_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  // Next-state, counter and decision logic; pulses default to zero each cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_latch_nxt  = r_latch;
    w_coin_nxt   = 2'b00;
    w_reject_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pat != 2'b00) begin
          w_latch_nxt = w_pat;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (w_pat == 2'b00) begin
          // Glitch: sensor dropped before it was stable long enough.
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_IDLE;
        end else if (w_pat != r_latch) begin
          w_latch_nxt = w_pat;
          w_cnt_nxt   = 8'd1;
        end else if (r_cnt == DEB_LAST) begin
          // This sample completes the stable run; accept_en is looked at only here.
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_RELEASE;
          if (bus.accept_en && (r_latch == 2'b01)) begin
            w_coin_nxt = 2'b01;
          end else if (bus.accept_en && (r_latch == 2'b10)) begin
            w_coin_nxt = 2'b10;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      ST_RELEASE: begin
        if (w_pat != 2'b00) begin
          w_cnt_nxt = 8'd0;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_HOLDOFF;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      ST_HOLDOFF: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      default: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = ST_RELEASE;
      end
    endcase
  end

  assign bus.coin   = r_coin;
  assign bus.reject = r_reject;
  assign bus.busy   = (r_state != ST_IDLE);

`ifdef COIN_ACCEPTOR_AUDIT_EN
  logic [7:0] r_acc_cnt;
  logic [7:0] r_rej_cnt;

  // Saturating audit counters, stepped on the same edge that raises the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt <= 8'd0;
      r_rej_cnt <= 8'd0;
    end else begin
      if ((w_coin_nxt != 2'b00) && (r_acc_cnt != 8'hFF)) begin
        r_acc_cnt <= r_acc_cnt + 8'd1;
      end
      if (w_reject_nxt && (r_rej_cnt != 8'hFF)) begin
        r_rej_cnt <= r_rej_cnt + 8'd1;
      end
    end
  end

  assign bus.accepted_cnt = r_acc_cnt;
  assign bus.rejected_cnt = r_rej_cnt;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus pushes expected pulses
// (code, reject, cycle) into a queue; a negedge monitor pops and compares.
module tb_coin_acceptor;
  localparam int DEB = 4;
  localparam int GAP = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [1:0] coin;
    logic       rej;
    int         at;
  } exp_t;

  exp_t sb[$];

  coin_acceptor_if bus ();

  coin_acceptor #(
    .DEB_CYCLES(DEB),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((bus.coin != 2'b00) || bus.reject)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: coin=%b reject=%b at cycle %0d, expected no pulse",
                 bus.coin, bus.reject, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.coin !== e.coin || bus.reject !== e.rej || cyc != e.at) begin
          errors++;
          $display("FAIL pulse: coin=%b reject=%b cycle=%0d, expected coin=%b reject=%b cycle=%0d",
                   bus.coin, bus.reject, cyc, e.coin, e.rej, e.at);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus.busy}, 32'd0);
  endtask

  // Raise the given sensors at a negedge for 'hold' clock edges; optionally
  // schedule the expected pulse DEB+2 edges after the launching negedge.
  task automatic insert(input logic s5, input logic s10, input int hold,
                        input logic [1:0] ecoin, input logic erej, input bit push,
                        output int c0);
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    if (push) begin
      e.coin = ecoin;
      e.rej  = erej;
      e.at   = c0 + 2 + DEB;
      sb.push_back(e);
    end
    bus.sense_5  = s5;
    bus.sense_10 = s10;
    repeat (hold) @(negedge clk);
    bus.sense_5  = 1'b0;
    bus.sense_10 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    bus.sense_5   = 1'b0;
    bus.sense_10  = 1'b0;
    bus.accept_en = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_coin",   {30'd0, bus.coin}, 32'd0);
    check("reset_reject", {31'd0, bus.reject}, 32'd0);
    check("reset_busy",   {31'd0, bus.busy}, 32'd1);

    // 1: startup passes RELEASE + HOLDOFF, then a clean 5-rupee coin.
    rst_n = 1'b1;
    c = cyc;
    wait_cyc(c + DEB + GAP - 1);
    check("startup_busy_hi", {31'd0, bus.busy}, 32'd1);
    wait_cyc(c + DEB + GAP);
    check("startup_busy_lo", {31'd0, bus.busy}, 32'd0);
    insert(1'b1, 1'b0, 12, 2'b01, 1'b0, 1'b1, c);
    wait_idle("idle_after_five");

    // 2: 2-cycle glitch on the 10 sensor is discarded.
    @(negedge clk);
    c = cyc;
    bus.sense_10 = 1'b1;
    repeat (2) @(negedge clk);
    bus.sense_10 = 1'b0;
    wait_cyc(c + 4);
    check("glitch_busy_hi", {31'd0, bus.busy}, 32'd1);
    wait_cyc(c + 5);
    check("glitch_busy_lo", {31'd0, bus.busy}, 32'd0);

    // 3: both sensors together are rejected.
    insert(1'b1, 1'b1, 8, 2'b00, 1'b1, 1'b1, c);
    wait_idle("idle_after_both");

    // 4: accept_en low rejects a 10; high credits it.
    bus.accept_en = 1'b0;
    insert(1'b0, 1'b1, 8, 2'b00, 1'b1, 1'b1, c);
    wait_idle("idle_after_ten_disabled");
    bus.accept_en = 1'b1;
    insert(1'b0, 1'b1, 8, 2'b10, 1'b0, 1'b1, c);
    wait_idle("idle_after_ten");

    // Reset during DEBOUNCE: outputs clear at once and the decision is lost.
    insert(1'b1, 1'b0, 4, 2'b00, 1'b0, 1'b0, c);
    bus.sense_5 = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midreset_coin",   {30'd0, bus.coin}, 32'd0);
    check("midreset_reject", {31'd0, bus.reject}, 32'd0);
    check("midreset_busy",   {31'd0, bus.busy}, 32'd1);
    repeat (2) @(negedge clk);
    bus.sense_5 = 1'b0;
    rst_n = 1'b1;
    wait_idle("idle_after_midreset");

    // 5: coin held through reset release is never credited.
    @(negedge clk);
    rst_n = 1'b0;
    bus.sense_5 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("held_busy", {31'd0, bus.busy}, 32'd1);
    c = cyc;
    bus.sense_5 = 1'b0;
    wait_cyc(c + 1 + DEB + GAP);
    check("held_release_busy_hi", {31'd0, bus.busy}, 32'd1);
    wait_cyc(c + 2 + DEB + GAP);
    check("held_release_busy_lo", {31'd0, bus.busy}, 32'd0);

    // 6: a 10 pulse during HOLDOFF is ignored.
    insert(1'b1, 1'b0, 8, 2'b01, 1'b0, 1'b1, c);
    wait_cyc(c + 14);
    bus.sense_10 = 1'b1;
    wait_cyc(c + 17);
    bus.sense_10 = 1'b0;
    wait_idle("idle_after_holdoff_pulse");
`ifdef COIN_ACCEPTOR_AUDIT_EN
    check("audit_accepted_1", {24'd0, bus.accepted_cnt}, 32'd1);
    check("audit_rejected_0", {24'd0, bus.rejected_cnt}, 32'd0);
`endif

    // Saturation run: 300 more accepted coins, alternating denominations.
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) insert(1'b1, 1'b0, 6, 2'b01, 1'b0, 1'b1, c);
      else            insert(1'b0, 1'b1, 6, 2'b10, 1'b0, 1'b1, c);
      wait_idle("idle_in_burst");
    end
`ifdef COIN_ACCEPTOR_AUDIT_EN
    check("audit_accepted_sat", {24'd0, bus.accepted_cnt}, 32'd255);
    check("audit_rejected_sat", {24'd0, bus.rejected_cnt}, 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
